// File: rtl/qsfp_iic_arbiter.sv
// Round-robin owner of the shared QSFP IIC byte engine: selects a cage, waits the
// module-select setup time, launches the engine and guards it with a watchdog.
module qsfp_iic_arbiter #(
  parameter int REQ_COUNT      = 3,
  parameter int QSFP_COUNT     = 2,
  parameter int SETTLE_CYCLES  = 200000,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 50000000,
  localparam int QSEL_W = (QSFP_COUNT > 1) ? $clog2(QSFP_COUNT) : 1,
  localparam int OWN_W  = $clog2(REQ_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_COUNT-1:0]        req,
  input  logic [REQ_COUNT*QSEL_W-1:0] reqQsfp,
  input  logic [QSFP_COUNT-1:0]       PRESENT_n,
  input  logic                        engineBusy,
  input  logic                        engineDone,
  output logic [REQ_COUNT-1:0]        grant,
  output logic [OWN_W-1:0]            owner,
  output logic [QSFP_COUNT-1:0]       modsel,
  output logic [QSEL_W-1:0]           engineQsfp,
  output logic                        engineStart,
  output logic                        engineAbort,
  output logic                        busy,
  output logic                        errAbsent,
  output logic                        errTimeout
);

  localparam int MAX_SH  = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
  localparam int MAX_CYC = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSENT,
    S_SETTLE,
    S_WAIT,
    S_HOLDOFF
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REQ_COUNT-1:0]    grant_q, grant_d;
  logic [OWN_W-1:0]        owner_q, owner_d;
  logic [QSFP_COUNT-1:0]   modsel_q, modsel_d;
  logic [QSEL_W-1:0]       qsel_q, qsel_d;
  logic                    start_q, start_d;
  logic                    abort_q, abort_d;
  logic                    errAbs_q, errAbs_d;
  logic                    errTo_q, errTo_d;

  logic                    anyReq;
  logic [OWN_W-1:0]        pick;
  logic [QSEL_W-1:0]       pickQsel;
  logic                    pickPresent;
  logic                    curPresent;
  logic                    cntZero;

  // Out-of-range cage indices fall through the loop and read as absent.
  function automatic logic cagePresent(input logic [QSEL_W-1:0] q,
                                       input logic [QSFP_COUNT-1:0] pn);
    logic p;
    p = 1'b0;
    for (int c = 0; c < QSFP_COUNT; c++) begin
      if (q == QSEL_W'(c)) p = ~pn[c];
    end
    return p;
  endfunction

  function automatic logic [QSFP_COUNT-1:0] cageOneHot(input logic [QSEL_W-1:0] q);
    logic [QSFP_COUNT-1:0] v;
    v = '0;
    for (int c = 0; c < QSFP_COUNT; c++) begin
      v[c] = (q == QSEL_W'(c));
    end
    return v;
  endfunction

  function automatic logic [REQ_COUNT-1:0] reqOneHot(input logic [OWN_W-1:0] idx);
    logic [REQ_COUNT-1:0] v;
    v = '0;
    for (int r = 0; r < REQ_COUNT; r++) begin
      v[r] = (idx == OWN_W'(r));
    end
    return v;
  endfunction

  // Scan from the farthest candidate back toward owner+1 so the nearest one wins.
  always_comb begin
    anyReq = |req;
    pick   = owner_q;
    for (int k = REQ_COUNT; k >= 1; k--) begin
      for (int r = 0; r < REQ_COUNT; r++) begin
        if (req[r] && (r == (int'(owner_q) + k) % REQ_COUNT)) pick = OWN_W'(r);
      end
    end
  end

  always_comb begin
    pickQsel = '0;
    for (int r = 0; r < REQ_COUNT; r++) begin
      if (pick == OWN_W'(r)) pickQsel = reqQsfp[r*QSEL_W +: QSEL_W];
    end
  end

  assign pickPresent = cagePresent(pickQsel, PRESENT_n);
  assign curPresent  = cagePresent(qsel_q, PRESENT_n);
  assign cntZero     = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      grant_q  <= '0;
      owner_q  <= OWN_W'(REQ_COUNT - 1);
      modsel_q <= '0;
      qsel_q   <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      errAbs_q <= 1'b0;
      errTo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      modsel_q <= modsel_d;
      qsel_q   <= qsel_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      errAbs_q <= errAbs_d;
      errTo_q  <= errTo_d;
    end
  end

  // Cage removal beats a coinciding settle expiry; done beats a coinciding watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (anyReq) state_d = pickPresent ? S_SETTLE : S_ABSENT;
      end
      S_ABSENT: state_d = S_IDLE;
      S_SETTLE: begin
        if (!curPresent)  state_d = S_HOLDOFF;
        else if (cntZero) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (engineDone || cntZero) state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (cntZero) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    owner_d  = owner_q;
    modsel_d = modsel_q;
    qsel_d   = qsel_q;
    cnt_d    = cntZero ? cnt_q : cnt_q - CNT_W'(1);
    start_d  = 1'b0;
    abort_d  = 1'b0;
    errAbs_d = 1'b0;
    errTo_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (anyReq) begin
          grant_d = reqOneHot(pick);
          owner_d = pick;
          qsel_d  = pickQsel;
          if (pickPresent) begin
            modsel_d = cageOneHot(pickQsel);
            cnt_d    = SETTLE_LOAD;
          end else begin
            errAbs_d = 1'b1;
          end
        end
      end
      S_ABSENT: grant_d = '0;
      S_SETTLE: begin
        if (!curPresent) begin
          modsel_d = '0;
          errAbs_d = 1'b1;
          cnt_d    = HOLDOFF_LOAD;
        end else if (cntZero) begin
          start_d = 1'b1;
          cnt_d   = TIMEOUT_LOAD;
        end
      end
      S_WAIT: begin
        if (engineDone) begin
          modsel_d = '0;
          cnt_d    = HOLDOFF_LOAD;
        end else if (cntZero) begin
          modsel_d = '0;
          abort_d  = 1'b1;
          errTo_d  = 1'b1;
          cnt_d    = HOLDOFF_LOAD;
        end
      end
      S_HOLDOFF: begin
        modsel_d = '0;
        if (cntZero) grant_d = '0;
      end
      default: begin
        grant_d  = '0;
        modsel_d = '0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign modsel      = modsel_q;
  assign engineQsfp  = qsel_q;
  assign engineStart = start_q;
  assign engineAbort = abort_q;
  assign errAbsent   = errAbs_q;
  assign errTimeout  = errTo_q;
  assign busy        = (state_q != S_IDLE) | engineBusy;

endmodule
